// File: rtl/dqpsk_pkg.sv
// Shared types and constants for the DQPSK transmit path.
package dqpsk_pkg;
    typedef enum logic [2:0] {IDLE, PRE, SYNC, LEN, PAY, TAIL} tx_state_t;

    localparam logic [15:0] DEF_SYNC_WORD = 16'hD391;
    // Alternating preamble word; MSB is the first preamble bit, so it starts with 1
    localparam logic [15:0] PRE_PATTERN   = 16'hAAAA;
    localparam int          CNT_W         = 16;
endpackage

// File: rtl/piso_shift.sv
// 16-bit parallel-load, MSB-first shift register; msb is the bit on the line.
module piso_shift (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic        shift,
    input  logic [15:0] din,
    output logic        msb
);
    logic [15:0] sr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)      sr <= '0;
        else if (load)  sr <= din;
        else if (shift) sr <= {sr[14:0], 1'b0};
    end

    assign msb = sr[15];
endmodule

// File: rtl/dqpsk_tx_frame_ctrl.sv
// Frame scheduler: preamble, sync, length, payload, tail, one bit per clk
// into the serial-to-parallel I/Q splitter.
module dqpsk_tx_frame_ctrl
    import dqpsk_pkg::*;
#(
    parameter int          PREAMBLE_BITS = 32,
    parameter logic [15:0] SYNC_WORD     = DEF_SYNC_WORD,
    parameter int          TAIL_BITS     = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] len,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       ser_data,
    output logic       ser_en,
    output logic       busy,
    output logic       sof,
    output logic       done,
    output logic       err_underrun
);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_BITS - 1);
    localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(TAIL_BITS - 1);

    tx_state_t        st;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       byte_cnt;
    logic [7:0]       len_q;
    logic             field_last;
    logic             more_bytes;
    logic             xfer;
    logic             underrun;
    logic             sh_load;
    logic             sh_shift;
    logic [15:0]      sh_din;

    always_comb begin
        field_last = 1'b0;
        case (st)
            PRE:      field_last = (cnt == PRE_LAST);
            SYNC:     field_last = (cnt == CNT_W'(15));
            LEN, PAY: field_last = (cnt == CNT_W'(7));
            TAIL:     field_last = (cnt == TAIL_LAST);
            default:  field_last = 1'b0;
        endcase
    end

    // A new byte is wanted at the end of LEN and of every payload byte but the last
    assign more_bytes = (st == LEN) ? (len_q != 8'd0) : (byte_cnt != len_q - 8'd1);
    assign byte_ready = field_last && (st == LEN || st == PAY) && more_bytes;
    assign xfer       = byte_ready & byte_valid;
    assign underrun   = byte_ready & ~byte_valid;

    always_comb begin
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_din   = '0;
        case (st)
            IDLE: if (start) begin
                sh_load = 1'b1;
                sh_din  = PRE_PATTERN;
            end
            PRE: begin
                if (field_last) begin
                    sh_load = 1'b1;
                    sh_din  = SYNC_WORD;
                end else if (cnt[3:0] == 4'hF) begin
                    // refill every 16 bits so preambles longer than one word keep alternating
                    sh_load = 1'b1;
                    sh_din  = PRE_PATTERN;
                end else begin
                    sh_shift = 1'b1;
                end
            end
            SYNC: begin
                if (field_last) begin
                    sh_load = 1'b1;
                    sh_din  = {len_q, 8'h00};
                end else begin
                    sh_shift = 1'b1;
                end
            end
            LEN, PAY: begin
                if (field_last) begin
                    sh_load = 1'b1;
                    sh_din  = xfer ? {byte_data, 8'h00} : 16'h0000;
                end else begin
                    sh_shift = 1'b1;
                end
            end
            default: sh_shift = 1'b1;
        endcase
    end

    piso_shift u_shift (
        .clk   (clk),
        .rstn  (rstn),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (sh_din),
        .msb   (ser_data)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st           <= IDLE;
            cnt          <= '0;
            byte_cnt     <= '0;
            len_q        <= '0;
            ser_en       <= 1'b0;
            busy         <= 1'b0;
            sof          <= 1'b0;
            done         <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            sof          <= 1'b0;
            done         <= 1'b0;
            err_underrun <= 1'b0;
            if (st != IDLE) cnt <= field_last ? '0 : cnt + 1'b1;
            case (st)
                IDLE: if (start) begin
                    st       <= PRE;
                    cnt      <= '0;
                    byte_cnt <= '0;
                    len_q    <= len;
                    ser_en   <= 1'b1;
                    busy     <= 1'b1;
                end
                PRE:  if (field_last) st <= SYNC;
                SYNC: if (field_last) st <= LEN;
                LEN, PAY: if (field_last) begin
                    if (xfer) begin
                        st       <= PAY;
                        sof      <= (st == LEN);
                        byte_cnt <= (st == PAY) ? byte_cnt + 8'd1 : 8'd0;
                    end else begin
                        st           <= TAIL;
                        err_underrun <= underrun;
                    end
                end
                TAIL: if (field_last) begin
                    st     <= IDLE;
                    ser_en <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dqpsk_tx_frame_ctrl.sv
// Bench for dqpsk_tx_frame_ctrl: vector table, corner sequences, random frames vs a bit-list model.
module tb_dqpsk_tx_frame_ctrl;
    localparam int          PB = 32;
    localparam int          TB = 4;
    localparam logic [15:0] SW = 16'hD391;

    logic       clk = 1'b0, rstn = 1'b1, start = 1'b0, byte_valid = 1'b0;
    logic [7:0] len = 8'd0, byte_data = 8'd0;
    logic       byte_ready, ser_data, ser_en, busy, sof, done, err_underrun;

    dqpsk_tx_frame_ctrl #(.PREAMBLE_BITS(PB), .SYNC_WORD(SW), .TAIL_BITS(TB)) dut (
        .clk(clk), .rstn(rstn), .start(start), .len(len), .byte_data(byte_data),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .ser_data(ser_data),
        .ser_en(ser_en), .busy(busy), .sof(sof), .done(done), .err_underrun(err_underrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    logic [7:0] pay [256];
    bit got_q[$];
    int r_ready, r_sof, r_sofpos, r_err, r_done, r_busy_bad, r_timeout, r_first_en;

    typedef struct {int len; int ur; int bits; int ready; int sof; int err;} vec_t;
    vec_t tbl [5];

    task automatic check(input string nm, input string what, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %0d expected %0d", nm, what, act, exp);
        end
    endtask

    task automatic fill_pay();
        for (int i = 0; i < 256; i++) pay[i] = 8'($urandom);
        pay[0] = 8'hA5;
        pay[1] = 8'h3C;
    endtask

    // Drives one frame; ur = index of the byte request answered with byte_valid low (-1: none)
    task automatic run_frame(input int L, input int ur, input int busy_at, input int abort_at,
                             input bit prestarted, input int chain_len);
        int req = 0, nxt = 0, cyc = 0;
        bit fin = 0;
        got_q.delete();
        r_ready = 0; r_sof = 0; r_sofpos = 0; r_err = 0; r_done = 0;
        r_busy_bad = 0; r_timeout = 0; r_first_en = 0;
        if (!prestarted) begin start = 1'b1; len = L[7:0]; end
        byte_valid = 1'b0;
        byte_data  = pay[0];
        while (!fin && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (abort_at == cyc) begin
                #2 rstn = 1'b0;
                #1;
                check("rst_mid", "ser_en", int'(ser_en), 0);
                check("rst_mid", "outs", int'({ser_data, busy, sof, done, err_underrun, byte_ready}), 0);
                return;
            end
            if (cyc == 1) r_first_en = int'(ser_en);
            if (ser_en) got_q.push_back(ser_data);
            if (busy !== ser_en) r_busy_bad++;
            if (sof) begin r_sof++; r_sofpos = got_q.size(); end
            if (err_underrun) r_err++;
            if (done) begin
                r_done++;
                fin = 1;
                if (chain_len >= 0) begin start = 1'b1; len = chain_len[7:0]; end
            end
            if (busy_at == cyc) begin start = 1'b1; len = 8'd9; end
            byte_valid = 1'b0;
            if (byte_ready) begin
                r_ready++;
                if (req != ur) begin byte_valid = 1'b1; byte_data = pay[nxt]; nxt++; end
                req++;
            end
        end
        if (!fin) r_timeout = 1;
    endtask

    // Reference: the frame as an explicit list of bits built from the field rules
    task automatic check_frame(input string nm, input int L, input int ur);
        bit exp_q[$];
        logic [7:0] b;
        int bad = -1;
        int n_ok, exp_ready;
        bit urun;
        urun = (ur >= 0 && ur < L);
        n_ok = urun ? ur : L;
        exp_ready = (L == 0) ? 0 : (urun ? ur + 1 : L);
        for (int i = 0; i < PB; i++) exp_q.push_back(i % 2 == 0);
        for (int i = 15; i >= 0; i--) exp_q.push_back(SW[i]);
        b = L[7:0];
        for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
        for (int k = 0; k < n_ok; k++) begin
            b = pay[k];
            for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
        end
        for (int i = 0; i < TB; i++) exp_q.push_back(1'b0);
        check(nm, "timeout", r_timeout, 0);
        check(nm, "frame_bits", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (bad < 0 && got_q[i] != exp_q[i]) bad = i;
        check(nm, "first_bad_bit", bad, -1);
        check(nm, "byte_ready_cnt", r_ready, exp_ready);
        check(nm, "sof_cnt", r_sof, (n_ok > 0) ? 1 : 0);
        check(nm, "sof_pos", r_sofpos, (n_ok > 0) ? PB + 25 : 0);
        check(nm, "err_cnt", r_err, urun ? 1 : 0);
        check(nm, "done_cnt", r_done, 1);
        check(nm, "busy_vs_en", r_busy_bad, 0);
    endtask

    initial begin
        int L, ur, n1, seen;
        tbl[0] = '{2,   -1, 76,   2,   1, 0};
        tbl[1] = '{0,   -1, 60,   0,   0, 0};
        tbl[2] = '{3,    1, 68,   2,   1, 1};
        tbl[3] = '{1,    0, 60,   1,   0, 1};
        tbl[4] = '{255, -1, 2100, 255, 1, 0};

        #2 rstn = 1'b0;
        #1;
        check("reset", "outs", int'({ser_data, ser_en, busy, sof, done, err_underrun, byte_ready}), 0);
        #20;
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            fill_pay();
            run_frame(tbl[i].len, tbl[i].ur, -1, -1, 1'b0, -1);
            check_frame($sformatf("vec%0d", i), tbl[i].len, tbl[i].ur);
            check($sformatf("vec%0d", i), "tbl_bits", got_q.size(), tbl[i].bits);
            check($sformatf("vec%0d", i), "tbl_ready", r_ready, tbl[i].ready);
            check($sformatf("vec%0d", i), "tbl_sof", r_sof, tbl[i].sof);
            check($sformatf("vec%0d", i), "tbl_err", r_err, tbl[i].err);
            repeat (2) @(posedge clk);
            #1;
        end

        // start with len=9 during payload of a len=2 frame must be ignored
        fill_pay();
        run_frame(2, -1, 60, -1, 1'b0, -1);
        check_frame("busy_start", 2, -1);
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ser_en || busy) seen++;
        end
        check("busy_start", "restart_cycles", seen, 0);

        // asynchronous reset in the middle of the payload
        fill_pay();
        run_frame(2, -1, -1, 60, 1'b0, -1);
        #20;
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        fill_pay();
        run_frame(1, -1, -1, -1, 1'b0, -1);
        check_frame("after_rst", 1, -1);
        check("after_rst", "frame_bits_68", got_q.size(), 68);

        // back-to-back frames: start raised in the done cycle
        repeat (2) @(posedge clk);
        #1;
        fill_pay();
        run_frame(3, -1, -1, -1, 1'b0, 2);
        n1 = got_q.size();
        check_frame("b2b_1", 3, -1);
        run_frame(2, -1, -1, -1, 1'b1, -1);
        check("b2b_2", "first_cycle_en", r_first_en, 1);
        check_frame("b2b_2", 2, -1);
        check("b2b", "dibit_parity", (n1 + got_q.size()) % 2, 0);

        for (int f = 0; f < 8; f++) begin
            repeat (int'($urandom_range(1, 3))) @(posedge clk);
            #1;
            fill_pay();
            L  = int'($urandom_range(0, 24));
            ur = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, L));
            run_frame(L, ur, -1, -1, 1'b0, -1);
            check_frame($sformatf("rand%0d", f), L, ur);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dqpsk_tx_frame_ctrl.md
# dqpsk_tx_frame_ctrl

Transmit frame scheduler for the DQPSK modem. It accepts a payload length and a byte stream and drives the serial input of the serial-to-parallel I/Q splitter, one bit per `clk`. Each frame is emitted as preamble, sync word, length byte, payload and tail. The total bit count is always even, so dibit alignment into the I/Q path is preserved across frames.

## Interface
- `PREAMBLE_BITS`, default 32: length of the alternating 1,0,1,0… preamble; must be even.
- `SYNC_WORD`, default 16'hD391: frame sync, sent MSB first.
- `TAIL_BITS`, default 4: zero bits appended to flush the differential encoder; must be even.
- `clk` input 1: data-bit clock.
- `rstn` input 1: asynchronous, active-low reset.
- `start` input 1: frame request; sampled only in IDLE.
- `len` input 8: payload byte count (0–255), latched with `start`.
- `byte_data` input 8: payload byte, MSB sent first.
- `byte_valid` input 1: `byte_data` is valid.
- `byte_ready` output 1: controller takes `byte_data` this cycle.
- `ser_data` output 1: serial bit to the splitter (`data_serial`).
- `ser_en` output 1: high for every frame bit; drives the splitter's enable/valid qualification.
- `busy` output 1: high from start acceptance until IDLE is re-entered.
- `sof` output 1: one-cycle pulse coincident with the first payload bit.
- `done` output 1: one-cycle pulse on IDLE re-entry.
- `err_underrun` output 1: one-cycle pulse when a byte was needed and `byte_valid` was low.

## Operation
- States and transitions:
  - IDLE → PRE on `start`.
  - PRE → SYNC after `PREAMBLE_BITS` bits.
  - SYNC → LEN after 16 bits.
  - LEN → PAY after 8 bits if `len` > 0; otherwise LEN → TAIL.
  - PAY → TAIL after 8·`len` bits or on underrun.
  - TAIL → IDLE after `TAIL_BITS` bits.
- Outputs in non-IDLE states:
  - `ser_en` = 1.
  - `ser_data` = the current bit of the state's word, MSB first.
  - Preamble starts with 1. Tail bits are 0.
- Outputs in IDLE: `ser_en` = 0, `ser_data` = 0.
- Byte fetch:
  - `byte_ready` is combinational. It is high on the last bit of LEN, and on the last bit of each payload byte except the final one.
  - A transfer occurs when `byte_ready` and `byte_valid` are both high. The byte is loaded into the shifter, so there are no bubbles between bytes.
- Underrun:
  - Condition: `byte_ready` high with `byte_valid` low.
  - `err_underrun` pulses and the remaining payload is dropped.
  - The next state is TAIL; the tail is sent in full.
  - `done` still pulses at the end.
- `start` while `busy` is ignored; `len` is not re-latched.
- Frame length is PREAMBLE_BITS + 24 + 8·len + TAIL_BITS cycles. With defaults this is 60 + 8·len cycles, always even.

## Timing
- Reset value of every output is 0; state is IDLE and all counters are 0. Reset takes effect immediately and asynchronously, including mid-frame. The first `start` after reset release is accepted normally.
- `ser_data`, `ser_en`, `busy`, `sof`, `done` and `err_underrun` are registered. `byte_ready` is combinational from state and counters only, never from `byte_valid`.
- Latency: the first preamble bit appears on `ser_data` on the `clk` edge that samples `start`.
- `done` pulses in the first IDLE cycle, when `busy` falls. A `start` in that same cycle is accepted, so back-to-back frames have exactly one idle cycle between them.
- `sof` is never asserted when `len` = 0.

## Structure
- Shared package `dqpsk_pkg`:
  - state enum `tx_state_t` (IDLE, PRE, SYNC, LEN, PAY, TAIL);
  - default `SYNC_WORD`;
  - preamble polarity constant;
  - bit-counter width constant (16 bits covers the longest field).
- One sub-module: `piso_shift`, a 16-bit parallel-load, MSB-first shift register with load/shift controls. The FSM, bit counter and byte counter stay in the top level.

## Test plan
- Nominal frame: `len`=2, bytes A5, 3C, always valid.
  - `ser_data` = 32 bits of 1010…, then D391, 02, A5, 3C, 0000 (MSB first).
  - `ser_en` is high for exactly 76 cycles.
  - `byte_ready` fires twice; `sof` fires once, at bit 57; `done` fires once.
- Empty frame: `len`=0 → 60 bits ending …D391, 00, 0000. `byte_ready` and `sof` are never asserted.
- Underrun: `len`=3, with `byte_valid` held low when the second byte is requested.
  - `err_underrun` pulses once.
  - The stream is A5 then 0000 directly after it.
  - Total frame is 60 + 8 = 68 cycles, followed by `done`.
- Start while busy: pulse `start` with `len`=9 mid-payload of a `len`=2 frame → no effect. The frame completes at 76 cycles and the next frame does not start.
- Reset mid-payload: drop `rstn` during PAY → all outputs read 0 in the same cycle. After release, a `len`=1 frame is emitted correctly in 68 cycles.
- Back-to-back: assert `start` on the `done` cycle → the second preamble begins after exactly one idle cycle, and dibit parity across both frames stays even.
